// File: rtl/cnt_bridge_pkg.sv
// Shared constants and types for the counter MMIO bridge.
// Register offsets are word indices taken from mem_addr[7:2].
package cnt_bridge_pkg;

  // Word offsets inside the 256-byte window
  localparam logic [5:0] OFF_CTRL   = 6'h00;  // byte 0x00
  localparam logic [5:0] OFF_COUNT  = 6'h01;  // byte 0x04
  localparam logic [5:0] OFF_SNAP   = 6'h02;  // byte 0x08
  localparam logic [5:0] OFF_STATUS = 6'h03;  // byte 0x0C
  localparam logic [5:0] OFF_CMP    = 6'h04;  // byte 0x10

  // CTRL bit positions
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_CMP_EN   = 4;
  localparam int CTRL_IRQ_EN   = 5;

  // Counter mode encodings (0 and 3 mean hold)
  localparam logic [1:0] MODE_UP   = 2'd1;
  localparam logic [1:0] MODE_DOWN = 2'd2;

  // Bus response FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // Word offset of a byte address within the window
  function automatic logic [5:0] reg_offset(input logic [31:0] addr);
    return addr[7:2];
  endfunction

endpackage

// File: rtl/cnt_bridge_match.sv
// Compare register, sticky match flag with write-1-to-clear, and the
// registered interrupt level derived from it.
module cnt_bridge_match
  import cnt_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cmp_we,      // per-byte write enables for CMP
  input  logic [31:0] wdata,
  input  logic        clr_match,   // STATUS write with bit 0 set
  input  logic        cmp_en,
  input  logic        irq_en,
  input  logic [31:0] cnt_count,
  output logic [31:0] cmp_value,
  output logic        match,
  output logic        irq
);

  logic hit;

  // Exact 32-bit equality; wrap-around needs no special case
  assign hit = cmp_en && (cnt_count == cmp_value);

  // CMP register with byte-granular writes
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_value <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (cmp_we[b]) cmp_value[b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Sticky match: a new hit takes priority over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      match <= 1'b0;
    end else if (hit) begin
      match <= 1'b1;
    end else if (clr_match) begin
      match <= 1'b0;
    end
  end

  // Interrupt level follows the registered match by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= match && irq_en;
    end
  end

endmodule

// File: rtl/counter_mmio_bridge.sv
// PicoRV32 native-bus slave in front of the 32-bit up/down counter.
// Optional compare/interrupt block is built when CNT_BRIDGE_IRQ_EN is defined.
//
// Handshake: a request is accepted when mem_valid is high, the address hits
// the window and the FSM is IDLE. The following cycle (ACK) mem_ready is high
// for exactly one cycle with mem_rdata valid; the FSM then returns to IDLE for
// at least one cycle, so ACK never repeats back to back. Requests outside the
// window are never acknowledged.
module counter_mmio_bridge
  import cnt_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter logic [1:0]  RESET_MODE = 2'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [1:0]  cnt_mode,
  input  logic [31:0] cnt_count,
  output logic        irq,
  output state_t      dbg_state
);

  state_t      state, state_nx;
  logic        sel;
  logic        accept;
  logic        is_write;
  logic [5:0]  off;
  logic        wr_ctrl;
  logic [1:0]  mode_q;
  logic [31:0] snap_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_data;
  logic [31:0] ctrl_rd;
  logic [31:0] status_rd;
  logic [31:0] cmp_rd;

  assign sel      = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign is_write = |mem_wstrb;
  assign off      = reg_offset(mem_addr);
  assign wr_ctrl  = accept && is_write && (off == OFF_CTRL) && mem_wstrb[0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state and accept strobe
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel) begin
          state_nx = ST_ACK;
          accept   = 1'b1;
        end
      end
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign mem_ready = (state == ST_ACK);
  assign mem_rdata = rdata_q;
  assign cnt_mode  = mode_q;
  assign dbg_state = state;

  // Read mux; COUNT returns the live counter at the accept edge
  always_comb begin
    rd_data = 32'h0;
    case (off)
      OFF_CTRL:   rd_data = ctrl_rd;
      OFF_COUNT:  rd_data = cnt_count;
      OFF_SNAP:   rd_data = snap_q;
      OFF_STATUS: rd_data = status_rd;
      OFF_CMP:    rd_data = cmp_rd;
      default:    rd_data = 32'h0;
    endcase
  end

  // Response data: captured on accept, zero outside the ACK cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'h0;
    end else if (accept) begin
      rdata_q <= is_write ? 32'h0 : rd_data;
    end else if (state == ST_ACK) begin
      rdata_q <= 32'h0;
    end
  end

  // Snapshot loaded by every COUNT read
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= 32'h0;
    end else if (accept && !is_write && (off == OFF_COUNT)) begin
      snap_q <= cnt_count;
    end
  end

  // Mode field of CTRL drives the counter directly
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= RESET_MODE;
    end else if (wr_ctrl) begin
      mode_q <= mem_wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
    end
  end

`ifdef CNT_BRIDGE_IRQ_EN
  logic        cmp_en_q;
  logic        irq_en_q;
  logic [3:0]  cmp_we;
  logic        clr_match;
  logic [31:0] cmp_value;
  logic        match;
  logic        unused_ok;

  assign cmp_we    = (accept && (off == OFF_CMP)) ? mem_wstrb : 4'b0000;
  assign clr_match = accept && (off == OFF_STATUS) && mem_wstrb[0] && mem_wdata[0];

  // Compare and interrupt enables in CTRL
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_en_q <= 1'b0;
      irq_en_q <= 1'b0;
    end else if (wr_ctrl) begin
      cmp_en_q <= mem_wdata[CTRL_CMP_EN];
      irq_en_q <= mem_wdata[CTRL_IRQ_EN];
    end
  end

  cnt_bridge_match u_match (
    .clk       (clk),
    .reset     (reset),
    .cmp_we    (cmp_we),
    .wdata     (mem_wdata),
    .clr_match (clr_match),
    .cmp_en    (cmp_en_q),
    .irq_en    (irq_en_q),
    .cnt_count (cnt_count),
    .cmp_value (cmp_value),
    .match     (match),
    .irq       (irq)
  );

  assign ctrl_rd   = {26'h0, irq_en_q, cmp_en_q, 2'b00, mode_q};
  assign status_rd = {31'h0, match};
  assign cmp_rd    = cmp_value;
  assign unused_ok = &{1'b0, mem_addr[1:0]};
`else
  logic unused_ok;

  assign ctrl_rd   = {30'h0, mode_q};
  assign status_rd = 32'h0;
  assign cmp_rd    = 32'h0;
  assign irq       = 1'b0;
  assign unused_ok = &{1'b0, mem_addr[1:0], mem_wdata[31:2]};
`endif

endmodule

// File: tb/tb_counter_mmio_bridge.sv
// Self-checking bench for counter_mmio_bridge: directed vector table plus
// hand-written sequences for latency, back-to-back, window decode, compare
// interrupt and reset-during-ACK behaviour.
module tb_counter_mmio_bridge;
  import cnt_bridge_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;
`ifdef CNT_BRIDGE_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  cnt_mode;
  logic [31:0] cnt_count;
  logic        irq;
  state_t      dbg_state;

  // Counter stand-in: either a fixed value or a free-running up/down counter
  logic        cnt_run = 1'b0;
  logic [31:0] cnt_fixed = 32'h0000_0100;
  logic [31:0] cnt_sim;

  int n_vec = 0;
  int n_err = 0;

  counter_mmio_bridge #(.BASE_ADDR(BASE), .RESET_MODE(2'd1)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .cnt_mode  (cnt_mode),
    .cnt_count (cnt_count),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Counter stand-in restarts at all-ones whenever not running
  always @(posedge clk) begin
    if (!cnt_run) cnt_sim <= 32'hFFFF_FFFF;
    else if (cnt_mode == MODE_UP) cnt_sim <= cnt_sim + 32'd1;
    else if (cnt_mode == MODE_DOWN) cnt_sim <= cnt_sim - 32'd1;
  end
  assign cnt_count = cnt_run ? cnt_sim : cnt_fixed;

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus transaction, started and finished on a negedge with the FSM idle
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata,
                          output int lat, output logic [1:0] mode_rdy);
    bit got;
    got = 1'b0;
    rdata = 32'h0;
    lat = 0;
    mode_rdy = cnt_mode;
    mem_addr = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (mem_ready) begin
        got = 1'b1;
        rdata = mem_rdata;
        mode_rdy = cnt_mode;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL bus timeout addr 0x%08h: no mem_ready in %0d cycles, required within 20", addr, lat);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [5:0] off, output logic [31:0] data);
    int l;
    logic [1:0] m;
    bus_xfer(BASE + {24'h0, off, 2'b00}, 32'h0, 4'h0, data, l, m);
  endtask

  task automatic wr(input logic [5:0] off, input logic [31:0] data, input logic [3:0] strb);
    int l;
    logic [1:0] m;
    logic [31:0] d;
    bus_xfer(BASE + {24'h0, off, 2'b00}, data, strb, d, l, m);
  endtask

  typedef struct {
    logic [5:0]  off;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] cnt;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_mode;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [31:0] r, r1, r2, r3;
    logic [1:0]  m;
    int          lat;
    int          ready_cnt;
    int          consec;
    logic        prev_ready;

    // Directed vector table
    vecs[0]  = '{OFF_CTRL,   32'h0,         4'h0, 32'h100,  32'h1, 2'd1};
    vecs[1]  = '{OFF_CTRL,   32'h2,         4'h1, 32'h100,  32'h0, 2'd2};
    vecs[2]  = '{OFF_CTRL,   32'h0,         4'h0, 32'h100,  32'h2, 2'd2};
    vecs[3]  = '{OFF_CTRL,   32'hFFFF_FFF3, 4'hE, 32'h100,  32'h0, 2'd2};
    vecs[4]  = '{OFF_CTRL,   32'h0,         4'h0, 32'h100,  32'h2, 2'd2};
    vecs[5]  = '{OFF_CTRL,   32'h33,        4'h1, 32'h100,  32'h0, 2'd3};
    vecs[6]  = '{OFF_CTRL,   32'h0,         4'h0, 32'h100,  IRQ ? 32'h33 : 32'h03, 2'd3};
    vecs[7]  = '{OFF_COUNT,  32'h0,         4'h0, 32'h1234, 32'h1234, 2'd3};
    vecs[8]  = '{OFF_SNAP,   32'h0,         4'h0, 32'h5678, 32'h1234, 2'd3};
    vecs[9]  = '{OFF_COUNT,  32'hDEAD,      4'hF, 32'h5678, 32'h0, 2'd3};
    vecs[10] = '{OFF_SNAP,   32'h0,         4'h0, 32'h5678, 32'h1234, 2'd3};
    vecs[11] = '{OFF_STATUS, 32'h0,         4'h0, 32'h5678, 32'h0, 2'd3};
    vecs[12] = '{OFF_CMP,    32'h1122_3344, 4'hF, 32'h5678, 32'h0, 2'd3};
    vecs[13] = '{OFF_CMP,    32'h0,         4'h0, 32'h5678, IRQ ? 32'h1122_3344 : 32'h0, 2'd3};
    vecs[14] = '{OFF_CMP,    32'hAAAA_AAAA, 4'h2, 32'h5678, 32'h0, 2'd3};
    vecs[15] = '{OFF_CMP,    32'h0,         4'h0, 32'h5678, IRQ ? 32'h1122_AA44 : 32'h0, 2'd3};
    vecs[16] = '{6'h10,      32'h0,         4'h0, 32'h5678, 32'h0, 2'd3};
    vecs[17] = '{6'h3F,      32'h0,         4'h0, 32'h5678, 32'h0, 2'd3};
    vecs[18] = '{OFF_CTRL,   32'h1,         4'h1, 32'h5678, 32'h0, 2'd1};
    vecs[19] = '{OFF_CTRL,   32'h0,         4'h0, 32'h5678, 32'h1, 2'd1};

    // Reset
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset cnt_mode", {30'h0, cnt_mode}, 32'h1);
    check("reset irq", {31'h0, irq}, 32'h0);
    check("reset mem_ready", {31'h0, mem_ready}, 32'h0);
    check("reset mem_rdata", mem_rdata, 32'h0);

    // Table
    for (int i = 0; i < 20; i++) begin
      cnt_fixed = vecs[i].cnt;
      bus_xfer(BASE + {24'h0, vecs[i].off, 2'b00}, vecs[i].wdata, vecs[i].wstrb, r, lat, m);
      check($sformatf("vec%0d rdata", i), r, vecs[i].exp_rdata);
      check($sformatf("vec%0d latency", i), lat, 32'd1);
      check($sformatf("vec%0d mode", i), {30'h0, m}, {30'h0, vecs[i].exp_mode});
    end

    // Count-down: successive COUNT reads decrease
    wr(OFF_CTRL, 32'h2, 4'h1);
    cnt_run = 1'b1;
    rd(OFF_COUNT, r1);
    rd(OFF_COUNT, r2);
    rd(OFF_COUNT, r3);
    check("down read1<=all-ones", {31'h0, (r1 <= 32'hFFFF_FFFF) && (r1 > 32'hFFFF_FF00)}, 32'h1);
    check("down read2<read1", {31'h0, r2 < r1}, 32'h1);
    check("down read3<read2", {31'h0, r3 < r2}, 32'h1);
    cnt_run = 1'b0;
    wr(OFF_CTRL, 32'h1, 4'h1);

    // Outside the window: held 10 cycles, never acknowledged
    mem_addr = BASE + 32'h100;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    ready_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ready) ready_cnt++;
    end
    mem_valid = 1'b0;
    check("out-of-window ready count", ready_cnt, 32'd0);
    @(posedge clk);
    @(negedge clk);

    // mem_valid held across ACK: ready pulses never back to back
    mem_addr = BASE + 32'h4;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    ready_cnt = 0;
    consec = 0;
    prev_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ready) ready_cnt++;
      if (mem_ready && prev_ready) consec++;
      prev_ready = mem_ready;
    end
    mem_valid = 1'b0;
    check("held valid ready pulses", ready_cnt, 32'd3);
    check("held valid consecutive ready", consec, 32'd0);
    @(posedge clk);
    @(negedge clk);

`ifdef CNT_BRIDGE_IRQ_EN
    // Compare match, sticky status, W1C, irq lag
    cnt_fixed = 32'h0F;
    wr(OFF_CMP, 32'h10, 4'hF);
    wr(OFF_CTRL, 32'h31, 4'h1);
    check("irq before match", {31'h0, irq}, 32'h0);
    rd(OFF_STATUS, r);
    check("status before match", r, 32'h0);
    cnt_fixed = 32'h10;
    @(posedge clk);
    @(negedge clk);
    check("irq lag on match", {31'h0, irq}, 32'h0);
    cnt_fixed = 32'h20;
    @(posedge clk);
    @(negedge clk);
    check("irq after match", {31'h0, irq}, 32'h1);
    rd(OFF_STATUS, r);
    check("status sticky", r, 32'h1);
    wr(OFF_STATUS, 32'h1, 4'h1);
    check("irq after w1c", {31'h0, irq}, 32'h0);
    rd(OFF_STATUS, r);
    check("status after w1c", r, 32'h0);
    // Clear lands on the same edge as a new match: set wins
    cnt_fixed = 32'h10;
    mem_addr = BASE + {24'h0, OFF_STATUS, 2'b00};
    mem_wdata = 32'h1;
    mem_wstrb = 4'h1;
    mem_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("simultaneous ack", {31'h0, mem_ready}, 32'h1);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    cnt_fixed = 32'h20;
    @(posedge clk);
    @(negedge clk);
    check("irq set wins", {31'h0, irq}, 32'h1);
    rd(OFF_STATUS, r);
    check("status set wins", r, 32'h1);
    wr(OFF_STATUS, 32'h1, 4'h1);
    wr(OFF_CTRL, 32'h1, 4'h1);
`else
    // Compare block absent: nothing matches, irq stays low
    cnt_fixed = 32'h10;
    wr(OFF_CMP, 32'h10, 4'hF);
    wr(OFF_CTRL, 32'h31, 4'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("no-irq build irq", {31'h0, irq}, 32'h0);
    rd(OFF_STATUS, r);
    check("no-irq build status", r, 32'h0);
    rd(OFF_CTRL, r);
    check("no-irq build ctrl", r, 32'h1);
`endif

    // Reset while in ACK abandons the transaction
    cnt_fixed = 32'h100;
    mem_addr = BASE + {24'h0, OFF_CTRL, 2'b00};
    mem_wdata = 32'h2;
    mem_wstrb = 4'h1;
    mem_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("pre-reset ack", {31'h0, mem_ready}, 32'h1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset in ack ready", {31'h0, mem_ready}, 32'h0);
    check("reset in ack mode", {30'h0, cnt_mode}, 32'h1);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rd(OFF_CTRL, r);
    check("ctrl after reset in ack", r, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
